// File: rtl/oled_screen_driver.sv
// SSD1306 128x64 OLED driver: power-up reset sequencing, fixed init command list, then an
// endless horizontal-addressing frame refresh over 4-wire SPI from a pipelined pixel source.
module oled_screen_driver #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000,
  parameter logic [7:0]  SPI_DIV      = 8'd1,
  parameter int          READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixelData,
  output logic [9:0] pixelAddress,
  output logic       frameDone,
  output logic       ioSclk,
  output logic       ioSdin,
  output logic       ioCs,
  output logic       ioDc,
  output logic       ioReset
);

  localparam logic [2:0] PWR_HI   = 3'd0;
  localparam logic [2:0] PWR_LO   = 3'd1;
  localparam logic [2:0] PWR_WAIT = 3'd2;
  localparam logic [2:0] LOAD_CMD = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] FETCH    = 3'd5;

  localparam logic [4:0] INIT_LEN   = 5'd20;
  localparam logic [7:0] FETCH_LAST = 8'(READ_LATENCY);

  logic [2:0]  state;
  logic [31:0] waitCnt;
  logic [7:0]  divCnt;
  logic [7:0]  fetchCnt;
  logic [2:0]  bitCnt;
  logic [4:0]  cmdIdx;
  logic [7:0]  shiftReg;
  logic [7:0]  romByte;
  logic        waitDone;
  logic        divDone;

  assign waitDone = (waitCnt == STARTUP_WAIT - 32'd1);
  assign divDone  = (divCnt == SPI_DIV - 8'd1);

  always_comb begin
    unique case (cmdIdx)
      5'd0:    romByte = 8'hAE;
      5'd1:    romByte = 8'h81;
      5'd2:    romByte = 8'h7F;
      5'd3:    romByte = 8'hA6;
      5'd4:    romByte = 8'h20;
      5'd5:    romByte = 8'h00;
      5'd6:    romByte = 8'hC8;
      5'd7:    romByte = 8'h40;
      5'd8:    romByte = 8'hA1;
      5'd9:    romByte = 8'hA8;
      5'd10:   romByte = 8'h3F;
      5'd11:   romByte = 8'hD5;
      5'd12:   romByte = 8'h80;
      5'd13:   romByte = 8'hD3;
      5'd14:   romByte = 8'h00;
      5'd15:   romByte = 8'hDA;
      5'd16:   romByte = 8'h12;
      5'd17:   romByte = 8'h8D;
      5'd18:   romByte = 8'h14;
      default: romByte = 8'hAF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PWR_HI;
      waitCnt      <= '0;
      divCnt       <= '0;
      fetchCnt     <= '0;
      bitCnt       <= '0;
      cmdIdx       <= '0;
      shiftReg     <= '0;
      pixelAddress <= '0;
      frameDone    <= 1'b0;
      ioSclk       <= 1'b1;
      ioSdin       <= 1'b0;
      ioCs         <= 1'b1;
      ioDc         <= 1'b0;
      ioReset      <= 1'b1;
    end else begin
      frameDone <= 1'b0;
      case (state)
        PWR_HI, PWR_LO, PWR_WAIT: begin
          waitCnt <= waitDone ? 32'd0 : waitCnt + 32'd1;
          if (waitDone) begin
            if (state == PWR_HI) begin
              state   <= PWR_LO;
              ioReset <= 1'b0;
            end else if (state == PWR_LO) begin
              state   <= PWR_WAIT;
              ioReset <= 1'b1;
            end else begin
              state <= LOAD_CMD;
              ioCs  <= 1'b0;
            end
          end
        end
        LOAD_CMD: begin
          shiftReg <= romByte;
          ioSdin   <= romByte[7];
          ioSclk   <= 1'b0;
          ioDc     <= 1'b0;
          bitCnt   <= 3'd7;
          divCnt   <= '0;
          cmdIdx   <= cmdIdx + 5'd1;
          state    <= SEND;
        end
        SEND: begin
          if (!divDone) begin
            divCnt <= divCnt + 8'd1;
          end else begin
            divCnt <= '0;
            if (!ioSclk) begin
              ioSclk <= 1'b1;
            end else if (bitCnt != 3'd0) begin
              ioSclk   <= 1'b0;
              ioSdin   <= shiftReg[6];
              shiftReg <= {shiftReg[6:0], 1'b0};
              bitCnt   <= bitCnt - 3'd1;
            end else begin
              // Byte finished; ioDc tells whether we were in the data phase
              fetchCnt <= '0;
              if (ioDc) begin
                pixelAddress <= pixelAddress + 10'd1;
                frameDone    <= (pixelAddress == 10'd1023);
                state        <= FETCH;
              end else if (cmdIdx < INIT_LEN) begin
                state <= LOAD_CMD;
              end else begin
                ioDc  <= 1'b1;
                state <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          if (fetchCnt == FETCH_LAST) begin
            shiftReg <= pixelData;
            ioSdin   <= pixelData[7];
            ioSclk   <= 1'b0;
            bitCnt   <= 3'd7;
            divCnt   <= '0;
            state    <= SEND;
          end else begin
            fetchCnt <= fetchCnt + 8'd1;
          end
        end
        default: state <= PWR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_screen_driver.sv
// Self-checking bench for oled_screen_driver: SPI byte decoder compared against a stream
// model built from the init list and the address-derived pixel pattern.
module tb_oled_screen_driver;

  localparam int HIST = 600;

  logic       clk;
  logic       reset;
  logic [7:0] pixelData;
  logic [9:0] pixelAddress;
  logic       frameDone;
  logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;

  oled_screen_driver #(
    .STARTUP_WAIT(32'd4),
    .SPI_DIV     (8'd1),
    .READ_LATENCY(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixelData   (pixelData),
    .pixelAddress(pixelAddress),
    .frameDone   (frameDone),
    .ioSclk      (ioSclk),
    .ioSdin      (ioSdin),
    .ioCs        (ioCs),
    .ioDc        (ioDc),
    .ioReset     (ioReset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage pixel source stub; optional noise everywhere except ahead of the capture edge
  logic [9:0] s1, s2;
  logic [7:0] noise;
  logic       noiseOn;
  int         edgeCnt;
  always @(posedge clk) begin
    s1      <= pixelAddress;
    s2      <= s1;
    noise   <= 8'($urandom);
    edgeCnt <= reset ? 0 : edgeCnt + 1;
  end
  assign pixelData = (noiseOn && (edgeCnt % 19 != 12)) ? noise : (s2[7:0] ^ 8'h5A);

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       dcOk;
    int         cyc;
  } rx_t;

  rx_t        rxQ[$];
  int         fdQ[$];
  logic       resetHist[HIST];
  logic       csHist[HIST];
  logic [9:0] addrHist[HIST];

  logic       prevSclk;
  logic [7:0] sh;
  int         nb;
  logic       dc0, dcOk;
  always @(negedge clk) begin
    if (reset) begin
      nb       = 0;
      prevSclk = 1'b1;
    end else begin
      if (edgeCnt < HIST) begin
        resetHist[edgeCnt] = ioReset;
        csHist[edgeCnt]    = ioCs;
        addrHist[edgeCnt]  = pixelAddress;
      end
      if (frameDone) fdQ.push_back(edgeCnt);
      if (!prevSclk && ioSclk) begin
        if (nb == 0) begin
          dc0  = ioDc;
          dcOk = 1'b1;
        end else if (ioDc != dc0) begin
          dcOk = 1'b0;
        end
        sh = {sh[6:0], ioSdin};
        nb++;
        if (nb == 8) begin
          rxQ.push_back('{sh, dc0, dcOk, edgeCnt});
          nb = 0;
        end
      end
      prevSclk = ioSclk;
    end
  end

  int nCmp = 0;
  int nFail = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference stream: 20 init commands, then page bytes for addresses 0,1,2,... wrapping at 1024
  localparam logic [7:0] INIT [20] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8,
      8'h40, 8'hA1, 8'hA8, 8'h3F, 8'hD5, 8'h80, 8'hD3, 8'h00, 8'hDA, 8'h12, 8'h8D, 8'h14,
      8'hAF};

  function automatic int expByte(input int k);
    logic [9:0] a;
    if (k < 20) return {23'd0, 1'b0, INIT[k]};
    a = 10'((k - 20) % 1024);
    return {23'd0, 1'b1, a[7:0] ^ 8'h5A};
  endfunction

  // Cycle of the last rising SCLK of byte k: 17-cycle init bytes, 19-cycle data bytes
  function automatic int expCyc(input int k);
    if (k < 20) return 28 + 17 * k;
    return 370 + 19 * (k - 20);
  endfunction

  typedef struct {
    int   cyc;
    logic rstPin;
    logic cs;
  } vec_t;
  vec_t vecs[8];

  task automatic releaseReset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    rxQ.delete();
    fdQ.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    for (int i = 0; i < budget && rxQ.size() < n; i++) @(negedge clk);
    check("byteCount", int'(rxQ.size() >= n), 1);
  endtask

  task automatic checkPowerUp(input string tag);
    foreach (vecs[i]) begin
      check($sformatf("%s_ioReset_c%0d", tag, vecs[i].cyc), int'(resetHist[vecs[i].cyc]),
            int'(vecs[i].rstPin));
      check($sformatf("%s_ioCs_c%0d", tag, vecs[i].cyc), int'(csHist[vecs[i].cyc]),
            int'(vecs[i].cs));
    end
  endtask

  task automatic checkStream(input string tag, input int n);
    for (int k = 0; k < n && k < rxQ.size(); k++) begin
      check($sformatf("%s_byte%0d", tag, k), int'({rxQ[k].dc, rxQ[k].data}), expByte(k));
      check($sformatf("%s_dcStable%0d", tag, k), int'(rxQ[k].dcOk), 1);
      check($sformatf("%s_cyc%0d", tag, k), rxQ[k].cyc, expCyc(k));
    end
  endtask

  int c;

  initial begin
    vecs[0] = '{0, 1'b1, 1'b1};
    vecs[1] = '{3, 1'b1, 1'b1};
    vecs[2] = '{4, 1'b0, 1'b1};
    vecs[3] = '{7, 1'b0, 1'b1};
    vecs[4] = '{8, 1'b1, 1'b1};
    vecs[5] = '{11, 1'b1, 1'b1};
    vecs[6] = '{12, 1'b1, 1'b0};
    vecs[7] = '{200, 1'b1, 1'b0};

    noiseOn = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ioSclk", int'(ioSclk), 1);
    check("rst_ioSdin", int'(ioSdin), 0);
    check("rst_ioCs", int'(ioCs), 1);
    check("rst_ioDc", int'(ioDc), 0);
    check("rst_ioReset", int'(ioReset), 1);
    check("rst_pixelAddress", int'(pixelAddress), 0);
    check("rst_frameDone", int'(frameDone), 0);

    // Two full frames with a clean source
    releaseReset();
    for (int i = 0; i < 42000 && fdQ.size() < 2; i++) @(negedge clk);
    check("frameDoneCount", fdQ.size(), 2);
    if (fdQ.size() >= 2) begin
      check("frameDone0_cyc", fdQ[0], 371 + 19 * 1023);
      check("frameDone1_cyc", fdQ[1], 371 + 19 * 1023 + 1024 * 19);
    end
    checkPowerUp("A");
    for (int n = 0; n < 4; n++)
      check($sformatf("A_addr%0d", n), int'(addrHist[353 + 19 * n]), n);
    checkStream("A", 20 + 2048);

    // Random garbage on pixelData except at the capture edge
    noiseOn = 1'b1;
    releaseReset();
    waitBytes(30, 2000);
    checkPowerUp("B");
    checkStream("B", 30);
    noiseOn = 1'b0;

    // Asynchronous reset in the middle of data byte 7, then full replay
    releaseReset();
    c = 487 + int'($urandom_range(0, 14));
    for (int i = 0; i < 2000 && edgeCnt < c; i++) @(negedge clk);
    check("C_reachCycle", edgeCnt, c);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("C_midReset_ioCs", int'(ioCs), 1);
    check("C_midReset_ioSclk", int'(ioSclk), 1);
    check("C_midReset_ioReset", int'(ioReset), 1);
    check("C_midReset_pixelAddress", int'(pixelAddress), 0);
    check("C_midReset_ioDc", int'(ioDc), 0);
    releaseReset();
    waitBytes(28, 2000);
    checkPowerUp("C");
    checkStream("C", 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
